freq_gen: RTL and testbench
===========================

Name: freq_gen

Overview:
- Programmable square-wave source: the stimulus end of the frequency-measurement path. It drives a known-frequency signal into the edge-counting timer.
- Software loads a half-period (in clock cycles) and an optional burst length, then starts the block.
- The block toggles `signal_out` at the programmed rate, counts rising edges sent, and reports completion.
- Used in lab self-test to close the loop: generator output feeds the counter input, and the counter result is compared against `edges_sent`.

Parameters:
- `WIDTH`, 32: width of the half-period, burst-length and edge-count registers.
- `DEFAULT_HALF`, 4: half-period value loaded at reset.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `load`  in  1  single-cycle strobe; captures `half_period` and `burst_len` (accepted in IDLE only).
- `half_period`  in  WIDTH  clock cycles per output level; 0 is treated as 1.
- `burst_len`  in  WIDTH  number of rising edges to emit; 0 means continuous.
- `start`  in  1  begin generation (accepted in IDLE only).
- `stop`  in  1  abort generation.
- `signal_out`  out  1  generated square wave.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when a finite burst completes.
- `edges_sent`  out  WIDTH  rising edges emitted since the last start.

Behaviour:
- Reset (`reset` low, asynchronous, any time, including mid-burst):
  - state=IDLE; `signal_out`=0, `busy`=0, `done`=0, `edges_sent`=0.
  - `half_reg`=`DEFAULT_HALF`, `burst_reg`=0, phase counter=0.
- Configuration:
  - `load` high in IDLE at an edge sets `half_reg` = max(`half_period`,1) and `burst_reg` = `burst_len`.
  - `load` in RUN is ignored; registers are unchanged.
- States: IDLE, RUN.
- IDLE -> RUN:
  - Occurs when `start`=1 and `stop`=0 at an edge.
  - `edges_sent` cleared to 0; phase counter loaded with `half_reg`-1; `signal_out` stays 0; `busy`=1 from the next cycle.
  - If `load` and `start` are high at the same edge, the newly loaded values govern this run.
- RUN, each edge:
  - If `stop`=1: go to IDLE, `signal_out`=0, `busy`=0, no `done` pulse, `edges_sent` holds its value.
  - Else if phase counter != 0: decrement the counter.
  - Else: toggle `signal_out` and reload the counter with `half_reg`-1.
    - A 0->1 toggle increments `edges_sent`, saturating at 2^WIDTH-1.
    - A 1->0 toggle with `burst_reg` != 0 and `edges_sent` == `burst_reg`: go to IDLE, `done`=1 for exactly one cycle, `busy`=0.
- Timing and latency:
  - With the start edge as edge 0 and H=`half_reg`, the first rising toggle occurs at edge H.
  - High for H cycles, low for H cycles; period 2H clocks, 50% duty.
  - A finite burst of N edges ends at edge 2HN: `signal_out` falls and `done` is high in the same cycle.
- Boundary conditions:
  - H=1: `signal_out` toggles every clock (period 2).
  - `start` during RUN is ignored.
  - `stop` in IDLE has no effect; `stop` has priority over `start` in the same cycle.
  - `burst_len`=0: runs until `stop` or reset; `edges_sent` saturates and does not wrap.
  - `edges_sent` is held after completion or stop, until the next start or reset.
  - Counter width: all arithmetic is WIDTH-bit unsigned. Reload of `half_reg`-1 never underflows because `half_reg` >= 1.

Test Plan:
- Reset release with no stimulus:
  - Expect `signal_out`=0, `busy`=0, `done`=0, `edges_sent`=0 for 20 cycles.
  - `start` alone then gives period 8 (`DEFAULT_HALF`=4).
- load H=2, N=3; start at edge 0:
  - `signal_out` rises at edges 2, 6, 10 and falls at edges 4, 8, 12.
  - `done` high only in the cycle after edge 12; `busy` low from edge 12; `edges_sent`=3 and held.
- load H=0, N=0; start:
  - `signal_out` toggles every clock.
  - `stop` asserted after 10 cycles: `signal_out`=0 next edge, `done` never pulses, `edges_sent`=5.
- load H=3, N=2; start:
  - At edge 4, assert `load` H=7 together with `start`: both ignored.
  - Waveform remains period 6 and completes with `done` at edge 12.
- Assert `reset` low asynchronously mid-high phase of a burst (H=5, N=10):
  - `signal_out`, `busy`, `edges_sent` go to 0 immediately without a clock edge.
  - After release, `half_reg`=4, verified by a fresh start.
- `start`+`stop` together in IDLE: state stays IDLE, `busy`=0. `load`+`start` together with H=1, N=1: single 1-cycle high pulse at edge 1, `done` at edge 2.

Source files
------------

// File: rtl/freq_gen.sv
// Programmable square-wave generator: toggles signal_out every half_reg clocks,
// counts rising edges and optionally stops after a finite burst.
module freq_gen #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEFAULT_HALF = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] half_period,
    input  logic [WIDTH-1:0] burst_len,
    input  logic             start,
    input  logic             stop,
    output logic             signal_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] edges_sent
);

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    localparam logic [WIDTH-1:0] HalfInit = WIDTH'(DEFAULT_HALF);
    localparam logic [WIDTH-1:0] One      = WIDTH'(1);
    localparam logic [WIDTH-1:0] EdgeMax  = '1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] half_q, half_d;
    logic [WIDTH-1:0] burst_q, burst_d;
    logic [WIDTH-1:0] phase_q, phase_d;
    logic [WIDTH-1:0] edges_q, edges_d;
    logic             sig_q, sig_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] load_half;
    logic [WIDTH-1:0] run_half;

    // A zero half-period would never toggle; clamp it to one cycle.
    assign load_half = (half_period == '0) ? One : half_period;
    // A load coinciding with start governs the run it launches.
    assign run_half  = load ? load_half : half_q;

    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        burst_d = burst_q;
        phase_d = phase_q;
        edges_d = edges_q;
        sig_d   = sig_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (load) begin
                    half_d  = load_half;
                    burst_d = burst_len;
                end
                if (start && !stop) begin
                    state_d = StRun;
                    edges_d = '0;
                    phase_d = run_half - One;
                    sig_d   = 1'b0;
                end
            end

            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                    sig_d   = 1'b0;
                end else if (phase_q != '0) begin
                    phase_d = phase_q - One;
                end else begin
                    sig_d   = ~sig_q;
                    phase_d = half_q - One;
                    if (!sig_q) begin
                        if (edges_q != EdgeMax) begin
                            edges_d = edges_q + One;
                        end
                    end else if ((burst_q != '0) && (edges_q == burst_q)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = StIdle;
                sig_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            half_q  <= HalfInit;
            burst_q <= '0;
            phase_q <= '0;
            edges_q <= '0;
            sig_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            burst_q <= burst_d;
            phase_q <= phase_d;
            edges_q <= edges_d;
            sig_q   <= sig_d;
            done_q  <= done_d;
        end
    end

    assign signal_out = sig_q;
    assign busy       = (state_q == StRun);
    assign done       = done_q;
    assign edges_sent = edges_q;

endmodule

// File: tb/tb_freq_gen.sv
// Bench for freq_gen: directed scenarios plus random stimulus against an
// arithmetic model of the waveform (position within the run -> level/count).
module tb_freq_gen;

    localparam int unsigned W = 8;
    localparam int EdgeMax = 255;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         load = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [W-1:0] half_period = '0;
    logic [W-1:0] burst_len = '0;
    logic         signal_out;
    logic         busy;
    logic         done;
    logic [W-1:0] edges_sent;

    int checks = 0;
    int failures = 0;

    // Model state: k counts edges since the start edge of the current run.
    bit m_run;
    int m_k, m_h, m_n, m_half_reg, m_burst_reg, m_edges;
    bit m_sig, m_done;

    freq_gen #(
        .WIDTH       (W),
        .DEFAULT_HALF(4)
    ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .half_period(half_period),
        .burst_len  (burst_len),
        .start      (start),
        .stop       (stop),
        .signal_out (signal_out),
        .busy       (busy),
        .done       (done),
        .edges_sent (edges_sent)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", tag, $time, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_run = 0; m_k = 0; m_h = 4; m_n = 0;
        m_half_reg = 4; m_burst_reg = 0; m_edges = 0; m_sig = 0; m_done = 0;
    endfunction

    function automatic void model_edge(input bit l, input bit s, input bit p, input int h,
                                       input int b);
        int e;
        m_done = 0;
        if (!m_run) begin
            if (l) begin
                m_half_reg = (h == 0) ? 1 : h;
                m_burst_reg = b;
            end
            if (s && !p) begin
                m_run = 1; m_k = 0; m_h = m_half_reg; m_n = m_burst_reg;
                m_edges = 0; m_sig = 0;
            end
        end else if (p) begin
            m_run = 0;
            m_sig = 0;
        end else begin
            m_k++;
            m_sig = ((m_k / m_h) % 2) == 1;
            e = (m_k + m_h) / (2 * m_h);
            m_edges = (e > EdgeMax) ? EdgeMax : e;
            if (m_n != 0 && m_k == 2 * m_h * m_n) begin
                m_run = 0;
                m_done = 1;
                m_sig = 0;
            end
        end
    endfunction

    task automatic compare_all();
        check_eq("signal_out", 32'(signal_out), 32'(m_sig));
        check_eq("busy", 32'(busy), 32'(m_run));
        check_eq("done", 32'(done), 32'(m_done));
        check_eq("edges_sent", 32'(edges_sent), 32'(m_edges));
    endtask

    // Called at a falling edge: apply inputs, clock once, compare at the next falling edge.
    task automatic drive(input bit l, input bit s, input bit p, input int h, input int b);
        load = l; start = s; stop = p;
        half_period = W'(h); burst_len = W'(b);
        @(posedge clock);
        model_edge(l, s, p, h, b);
        @(negedge clock);
        compare_all();
        load = 0; start = 0; stop = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clock);
        compare_all();
        reset = 1'b1;

        // Reset release, no stimulus, then default half-period of 4.
        idle(20);
        drive(0, 1, 0, 0, 0);
        idle(20);
        drive(0, 0, 1, 0, 0);
        idle(2);

        // H=2, N=3 burst, then held count; start during the run is ignored.
        drive(1, 0, 0, 2, 3);
        drive(0, 1, 0, 0, 0);
        idle(5);
        drive(0, 1, 0, 0, 0);
        idle(12);

        // H=0 behaves as H=1, continuous; stop after 10 cycles.
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        idle(9);
        drive(0, 0, 1, 0, 0);
        check_eq("edges_after_stop", 32'(edges_sent), 32'd5);
        idle(4);

        // Load+start during RUN ignored.
        drive(1, 0, 0, 3, 2);
        drive(0, 1, 0, 0, 0);
        idle(3);
        drive(1, 1, 0, 7, 0);
        idle(10);

        // Asynchronous reset mid-high phase of an H=5, N=10 burst.
        drive(1, 0, 0, 5, 10);
        drive(0, 1, 0, 0, 0);
        idle(7);
        #2 reset = 1'b0;
        #1;
        check_eq("async_sig", 32'(signal_out), 32'd0);
        check_eq("async_busy", 32'(busy), 32'd0);
        check_eq("async_edges", 32'(edges_sent), 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        drive(0, 1, 0, 0, 0);
        idle(18);
        drive(0, 0, 1, 0, 0);

        // start+stop in IDLE, then load+start with H=1, N=1.
        drive(0, 1, 1, 0, 0);
        drive(1, 1, 0, 1, 1);
        idle(4);

        // Continuous H=1 long enough to saturate the 8-bit edge count.
        drive(1, 1, 0, 1, 0);
        idle(520);
        drive(0, 0, 1, 0, 0);
        idle(2);

        // Random configuration and control traffic.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(9) == 0, $urandom_range(5) == 0, $urandom_range(39) == 0,
                  int'($urandom_range(6)), int'($urandom_range(5)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
